// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states
// and the access size / legality decode.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    RESP = 2'd3
  } state_t;

  // Access size in bytes (1/2/4); 0 for encodings that name no width.
  function automatic logic [2:0] access_size(input logic [2:0] funct3);
    logic [2:0] size;
    case (funct3)
      F3_B, F3_BU: size = 3'd1;
      F3_H, F3_HU: size = 3'd2;
      F3_W:        size = 3'd4;
      default:     size = 3'd0;
    endcase
    return size;
  endfunction

  // Stores only know B/H/W; loads additionally accept the unsigned forms.
  function automatic logic access_legal(input logic we, input logic [2:0] funct3);
    logic legal;
    case (funct3)
      F3_B, F3_H, F3_W: legal = 1'b1;
      F3_BU, F3_HU:     legal = ~we;
      default:          legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/load_store_unit_lane_merge.sv
// Combinational byte-lane logic: merges store bytes into the word being
// rewritten and extracts/extends load data from the two captured words.
module lsu_lane_merge (
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  input  logic [2:0]  size,
  input  logic        hi_sel,
  input  logic [31:0] wdata,
  input  logic [31:0] mem_rd,
  input  logic [31:0] lo_word,
  input  logic [31:0] hi_word,
  output logic [31:0] wd,
  output logic [31:0] rdata
);
  import lsu_pkg::*;

  logic [3:0]  base_mask_s;
  logic [7:0]  lane_mask_s;
  logic [3:0]  sel_mask_s;
  logic [63:0] wdata_sh_s;
  logic [63:0] rd_sh_s;
  logic [31:0] raw_s;

  // Store merge: a 64-bit view spans both words, so overflow lanes fall into the high word.
  always_comb begin
    case (size)
      3'd1:    base_mask_s = 4'b0001;
      3'd2:    base_mask_s = 4'b0011;
      3'd4:    base_mask_s = 4'b1111;
      default: base_mask_s = 4'b0000;
    endcase
    lane_mask_s = {4'b0000, base_mask_s} << offset;
    wdata_sh_s  = {32'h0000_0000, wdata} << {offset, 3'b000};
    sel_mask_s  = hi_sel ? lane_mask_s[7:4] : lane_mask_s[3:0];
    wd = mem_rd;
    for (int i = 0; i < 4; i++) begin
      if (sel_mask_s[i]) begin
        wd[8*i +: 8] = hi_sel ? wdata_sh_s[32 + 8*i +: 8] : wdata_sh_s[8*i +: 8];
      end else begin
        wd[8*i +: 8] = mem_rd[8*i +: 8];
      end
    end
  end

  // Load extract: shift the word pair down by the offset, then extend.
  always_comb begin
    rd_sh_s = {hi_word, lo_word} >> {offset, 3'b000};
    raw_s   = rd_sh_s[31:0];
    case (funct3)
      F3_B:    rdata = {{24{raw_s[7]}}, raw_s[7:0]};
      F3_H:    rdata = {{16{raw_s[15]}}, raw_s[15:0]};
      F3_W:    rdata = raw_s;
      F3_BU:   rdata = {24'h00_0000, raw_s[7:0]};
      F3_HU:   rdata = {16'h0000, raw_s[15:0]};
      default: rdata = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-port load/store unit: byte/half/word accesses of any alignment,
// split into at most two word accesses, with read-modify-write for stores.
module load_store_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [31:0]       mem_a,
  output logic              mem_we,
  output logic [31:0]       mem_wd,
  input  logic [31:0]       mem_rd
);
  import lsu_pkg::*;

  state_t            state_r, state_s;
  logic [ADDR_W-1:0] addr_r;
  logic              we_r;
  logic [2:0]        funct3_r;
  logic [31:0]       wdata_r;
  logic [31:0]       lo_word_r;
  logic [31:0]       hi_word_r;

  logic              accept_s;
  logic              legal_s;
  logic [2:0]        size_s;
  logic              span_s;
  logic              hi_sel_s;
  logic [ADDR_W-3:0] word_s;
  logic [31:0]       merge_wd_s;
  logic [31:0]       extract_s;
  logic              in_resp_s;

  assign req_ready = (state_r == IDLE);
  assign accept_s  = req_valid & req_ready;
  assign legal_s   = access_legal(we_r, funct3_r);
  assign size_s    = access_size(funct3_r);
  assign span_s    = (({2'b00, addr_r[1:0]} + {1'b0, size_s}) > 4'd4);
  assign in_resp_s = (state_r == RESP) & ~rst;

  assign rsp_valid = in_resp_s;
  assign rsp_err   = in_resp_s & ~legal_s;
  assign rsp_rdata = (in_resp_s & legal_s & ~we_r) ? extract_s : 32'h0000_0000;

  lsu_lane_merge u_lane_merge (
    .offset  (addr_r[1:0]),
    .funct3  (funct3_r),
    .size    (size_s),
    .hi_sel  (hi_sel_s),
    .wdata   (wdata_r),
    .mem_rd  (mem_rd),
    .lo_word (lo_word_r),
    .hi_word (hi_word_r),
    .wd      (merge_wd_s),
    .rdata   (extract_s)
  );

  // Next state and memory port; reset forces the port idle so an aborted access writes nothing.
  always_comb begin
    state_s  = state_r;
    hi_sel_s = 1'b0;
    word_s   = addr_r[ADDR_W-1:2];
    mem_a    = 32'h0000_0000;
    mem_we   = 1'b0;
    mem_wd   = 32'h0000_0000;
    if (rst) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            state_s = access_legal(req_we, req_funct3) ? LO : RESP;
          end else begin
            state_s = IDLE;
          end
        end
        LO: begin
          mem_a   = 32'(word_s);
          mem_we  = we_r;
          mem_wd  = we_r ? merge_wd_s : 32'h0000_0000;
          state_s = span_s ? HI : RESP;
        end
        HI: begin
          hi_sel_s = 1'b1;
          word_s   = addr_r[ADDR_W-1:2] + {{(ADDR_W-3){1'b0}}, 1'b1};
          mem_a    = 32'(word_s);
          mem_we   = we_r;
          mem_wd   = we_r ? merge_wd_s : 32'h0000_0000;
          state_s  = RESP;
        end
        RESP:    state_s = IDLE;
        default: state_s = IDLE;
      endcase
    end
  end

  // State, request capture and load-word capture registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      addr_r    <= '0;
      we_r      <= 1'b0;
      funct3_r  <= 3'b000;
      wdata_r   <= 32'h0000_0000;
      lo_word_r <= 32'h0000_0000;
      hi_word_r <= 32'h0000_0000;
    end else begin
      state_r <= state_s;
      if (accept_s) begin
        addr_r   <= req_addr;
        we_r     <= req_we;
        funct3_r <= req_funct3;
        wdata_r  <= req_wdata;
      end
      if (state_r == LO && !we_r) begin
        lo_word_r <= mem_rd;
      end
      if (state_r == HI && !we_r) begin
        hi_word_r <= mem_rd;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized self-checking bench for load_store_unit against a byte-level
// memory model; directed cases cover the worked examples and reset abort.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_a;
  logic        mem_we;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  logic [31:0] dmem [16];
  logic        pre_we;
  logic [3:0]  pre_idx;
  logic [31:0] pre_val;
  logic [7:0]  ref_b [64];

  int checks = 0;
  int errors = 0;
  logic [31:0] last_rdata;
  logic        last_err;
  int          last_we_pulses;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_a(mem_a), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  // 16-word memory aliased on the low index bits; async read, write on clk.
  assign mem_rd = dmem[mem_a[3:0]];
  always @(posedge clk) begin
    if (pre_we) dmem[pre_idx] <= pre_val;
    else if (mem_we) dmem[mem_a[3:0]] <= mem_wd;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%08h exp=%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input int w);
    return {ref_b[4*w+3], ref_b[4*w+2], ref_b[4*w+1], ref_b[4*w]};
  endfunction

  task automatic preload(input int w, input logic [31:0] v);
    pre_we  = 1'b1;
    pre_idx = 4'(w);
    pre_val = v;
    for (int k = 0; k < 4; k++) ref_b[4*w+k] = v[8*k +: 8];
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic check_mem(input string tag);
    for (int w = 0; w < 16; w++) check_eq(tag, dmem[w], ref_word(w));
  endtask

  // Issue one request from an IDLE cycle (called at a negedge) and check it cycle by cycle.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input bit abort_hi);
    bit          legal;
    bit          span;
    int          size;
    int          lat;
    logic [31:0] exp_rd;
    logic [31:0] exp_a [3];
    logic [31:0] ba;
    logic [31:0] first_w;

    legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    span  = legal && ((int'(addr[1:0]) + size) > 4);
    lat   = !legal ? 1 : (span ? 3 : 2);
    exp_a[0] = 32'h0;
    exp_a[1] = addr >> 2;
    exp_a[2] = ((addr >> 2) + 32'd1) & 32'h3FFF_FFFF;
    first_w  = addr >> 2;

    exp_rd = 32'h0;
    if (legal && !we) begin
      for (int i = 0; i < size; i++) begin
        ba = addr + 32'(i);
        exp_rd[8*i +: 8] = ref_b[ba[5:0]];
      end
      if (f3 == 3'd0) exp_rd = 32'($signed(exp_rd[7:0]));
      if (f3 == 3'd1) exp_rd = 32'($signed(exp_rd[15:0]));
    end

    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    check_eq("ready_idle", 32'(req_ready), 32'd1);
    @(posedge clk);
    last_we_pulses = 0;
    for (int n = 1; n <= lat; n++) begin
      @(negedge clk);
      if (n < lat) begin
        check_eq("busy_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("busy_ready", 32'(req_ready), 32'd0);
        check_eq("busy_mem_a", mem_a, exp_a[n]);
        check_eq("busy_mem_we", 32'(mem_we), 32'(we));
        if (mem_we) last_we_pulses++;
        req_valid  = 1'($urandom_range(0, 1));
        req_we     = 1'($urandom_range(0, 1));
        req_funct3 = 3'($urandom_range(0, 7));
        req_addr   = $urandom;
        req_wdata  = $urandom;
        if (abort_hi && n == 2) begin
          req_valid = 1'b0;
          rst = 1'b1;
          #1;
          check_eq("abort_we_now", 32'(mem_we), 32'd0);
          @(negedge clk);
          check_eq("abort_we", 32'(mem_we), 32'd0);
          check_eq("abort_ready", 32'(req_ready), 32'd1);
          check_eq("abort_rsp_valid", 32'(rsp_valid), 32'd0);
          rst = 1'b0;
          break;
        end
      end else begin
        check_eq("rsp_valid", 32'(rsp_valid), 32'd1);
        check_eq("rsp_err", 32'(rsp_err), 32'(!legal));
        check_eq("rsp_rdata", rsp_rdata, exp_rd);
        check_eq("resp_mem_we", 32'(mem_we), 32'd0);
        check_eq("resp_mem_a", mem_a, 32'd0);
        check_eq("resp_mem_wd", mem_wd, 32'd0);
        last_rdata = rsp_rdata;
        last_err   = rsp_err;
        req_valid  = 1'b0;
        @(negedge clk);
      end
    end

    if (legal && we) begin
      for (int i = 0; i < size; i++) begin
        ba = addr + 32'(i);
        if (!abort_hi || ((ba >> 2) == first_w)) ref_b[ba[5:0]] = wdata[8*i +: 8];
      end
    end
    check_mem("mem");
  endtask

  initial begin
    logic [31:0] a;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'h0; req_wdata = 32'h0; pre_we = 1'b0; pre_idx = 4'd0; pre_val = 32'h0;
    last_rdata = 32'h0; last_err = 1'b0; last_we_pulses = 0;
    @(negedge clk);
    for (int w = 0; w < 16; w++) preload(w, $urandom);
    check_eq("rst_ready", 32'(req_ready), 32'd1);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_rsp_rdata", rsp_rdata, 32'd0);
    check_eq("rst_rsp_err", 32'(rsp_err), 32'd0);
    check_eq("rst_mem_we", 32'(mem_we), 32'd0);
    check_eq("rst_mem_a", mem_a, 32'd0);
    check_eq("rst_mem_wd", mem_wd, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    preload(1, 32'h8877_6655);
    preload(2, 32'h4433_2211);
    do_req(1'b0, 3'b000, 32'h7, 32'h0, 1'b0);
    check_eq("lb_0x7", last_rdata, 32'hFFFF_FF88);
    do_req(1'b0, 3'b100, 32'h7, 32'h0, 1'b0);
    check_eq("lbu_0x7", last_rdata, 32'h0000_0088);
    do_req(1'b1, 3'b001, 32'h6, 32'h0000_BEEF, 1'b0);
    check_eq("sh_word1", dmem[1], 32'hBEEF_6655);
    check_eq("sh_pulses", 32'(last_we_pulses), 32'd1);

    preload(1, 32'h8877_6655);
    do_req(1'b0, 3'b010, 32'h6, 32'h0, 1'b0);
    check_eq("lw_span", last_rdata, 32'h2211_8877);
    do_req(1'b1, 3'b010, 32'h7, 32'hAABB_CCDD, 1'b0);
    check_eq("sw_word1", dmem[1], 32'hDD77_6655);
    check_eq("sw_word2", dmem[2], 32'h44AA_BBCC);
    check_eq("sw_pulses", 32'(last_we_pulses), 32'd2);
    do_req(1'b0, 3'b011, 32'h10, 32'h0, 1'b0);
    check_eq("err_flag", 32'(last_err), 32'd1);
    check_eq("err_rdata", last_rdata, 32'd0);

    preload(1, 32'h8877_6655);
    preload(2, 32'h4433_2211);
    do_req(1'b1, 3'b010, 32'h7, 32'hAABB_CCDD, 1'b1);
    check_eq("abort_word1", dmem[1], 32'hDD77_6655);
    check_eq("abort_word2", dmem[2], 32'h4433_2211);

    do_req(1'b0, 3'b010, 32'hFFFF_FFFE, 32'h0, 1'b0);
    do_req(1'b1, 3'b001, 32'hFFFF_FFFF, 32'h0000_5AA5, 1'b0);

    for (int t = 0; t < 300; t++) begin
      if ($urandom_range(0, 9) == 0) a = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
      else a = 32'($urandom_range(0, 63));
      do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
